hue_sequencer: RTL and testbench

Upstream colour source for the three per-channel pwm instances on the RGB LED. It replaces three free-running ramps with one coordinated colour-wheel walk: red→yellow→green→cyan→blue→magenta→red.
It produces red/green/blue duty values. Each value is committed only at a PWM period boundary, so a duty change never lands mid-period.

---
 rtl/hue_pkg.sv | 18 +
 rtl/tick_gen.sv | 41 ++++
 rtl/hue_sequencer.sv | 125 ++++++++++++
 tb/tb_hue_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hue_pkg.sv
// rtl/hue_pkg.sv - shared types and constants for the hue colour-wheel sequencer
// Purpose : sector type and named sector codes for the six-sector colour wheel.
// Ports   : none (package).
package hue_pkg;

    typedef logic [2:0] sector_t;

    localparam int NUM_SECTORS = 6;

    // Named after the channel that is held at full scale and the channel that ramps.
    localparam sector_t SECTOR_RED_UP_G = 3'd0;
    localparam sector_t SECTOR_GRN_DN_R = 3'd1;
    localparam sector_t SECTOR_GRN_UP_B = 3'd2;
    localparam sector_t SECTOR_BLU_DN_G = 3'd3;
    localparam sector_t SECTOR_BLU_UP_R = 3'd4;
    localparam sector_t SECTOR_MAG_DN_B = 3'd5;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enable-gated prescaler producing one tick every TICK_DIV clocks
// Purpose : counts 0..TICK_DIV-1 while enabled; tick is high on the last count.
// Ports   : clk    - system clock
//           rst    - synchronous active-high reset
//           enable - high = count; low = hold count, no ticks
//           tick   - high in the cycle the count is TICK_DIV-1 and enable is high
module tick_gen
    import hue_pkg::*;
#(
    parameter int TICK_DIV = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    generate
        if (TICK_DIV < 1) begin : g_bad_div
            $error("tick_gen: TICK_DIV must be >= 1");
        end
    endgenerate

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign tick      = enable & w_at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_at_last ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/hue_sequencer.sv
// rtl/hue_sequencer.sv - colour-wheel walk with duty commit on PWM period boundaries
// Purpose : walks red->yellow->green->cyan->blue->magenta->red and presents
//           RGB duty values that only change at a PWM period start.
// Ports   : clk              - system clock
//           rst              - synchronous active-high reset
//           enable           - high = advance through the wheel; low = freeze
//           pwm_period_start - commit strobe from the pwm block
//           red_duty         - committed red duty
//           green_duty       - committed green duty
//           blue_duty        - committed blue duty
//           sector           - live hue sector 0..5
//           update           - high in the cycle the duty outputs take a new commit
module hue_sequencer
    import hue_pkg::*;
#(
    parameter int TICK_DIV = 20000,
    parameter int PWM_MAX  = 100,
    parameter int DUTY_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              pwm_period_start,
    output logic [DUTY_W-1:0] red_duty,
    output logic [DUTY_W-1:0] green_duty,
    output logic [DUTY_W-1:0] blue_duty,
    output logic [2:0]        sector,
    output logic              update
);

    generate
        if (PWM_MAX > (2**DUTY_W) - 1) begin : g_bad_width
            $error("hue_sequencer: PWM_MAX does not fit in DUTY_W bits");
        end
        if (PWM_MAX < 2) begin : g_bad_max
            $error("hue_sequencer: PWM_MAX must be >= 2");
        end
    endgenerate

    localparam logic [DUTY_W-1:0] L_FULL = DUTY_W'(PWM_MAX);
    localparam logic [DUTY_W-1:0] L_LAST = DUTY_W'(PWM_MAX - 1);

    logic              w_step_tick;
    logic [DUTY_W-1:0] r_level;
    sector_t           r_sector;
    logic [DUTY_W-1:0] w_up;
    logic [DUTY_W-1:0] w_dn;
    logic [DUTY_W-1:0] w_red;
    logic [DUTY_W-1:0] w_green;
    logic [DUTY_W-1:0] w_blue;
    logic [DUTY_W-1:0] r_red;
    logic [DUTY_W-1:0] r_green;
    logic [DUTY_W-1:0] r_blue;
    logic              r_update;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (w_step_tick)
    );

    // Level ramps 0..PWM_MAX-1 inside a sector; the wrap moves to the next sector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level  <= '0;
            r_sector <= SECTOR_RED_UP_G;
        end else if (w_step_tick) begin
            if (r_level < L_LAST) begin
                r_level <= r_level + DUTY_W'(1);
            end else begin
                r_level  <= '0;
                r_sector <= (r_sector == SECTOR_MAG_DN_B) ? SECTOR_RED_UP_G
                                                          : r_sector + 3'd1;
            end
        end
    end

    // Level never exceeds PWM_MAX-1, so the down ramp cannot underflow and it
    // starts at full scale, giving no repeated colour across a sector edge.
    assign w_up = r_level;
    assign w_dn = L_FULL - r_level;

    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        case (r_sector)
            SECTOR_RED_UP_G: begin w_red = L_FULL; w_green = w_up;   end
            SECTOR_GRN_DN_R: begin w_red = w_dn;   w_green = L_FULL; end
            SECTOR_GRN_UP_B: begin w_green = L_FULL; w_blue = w_up;  end
            SECTOR_BLU_DN_G: begin w_green = w_dn; w_blue = L_FULL;  end
            SECTOR_BLU_UP_R: begin w_red = w_up;   w_blue = L_FULL;  end
            SECTOR_MAG_DN_B: begin w_red = L_FULL; w_blue = w_dn;    end
            default:         begin w_red = '0;     w_green = '0;     end
        endcase
    end

    // Commit samples the pre-tick staged colour, so a step coinciding with a
    // period start is shown at the following period start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_update <= 1'b0;
        end else if (pwm_period_start) begin
            r_red    <= w_red;
            r_green  <= w_green;
            r_blue   <= w_blue;
            r_update <= 1'b1;
        end else begin
            r_update <= 1'b0;
        end
    end

    assign red_duty   = r_red;
    assign green_duty = r_green;
    assign blue_duty  = r_blue;
    assign sector     = r_sector;
    assign update     = r_update;

endmodule

// File: tb/tb_hue_sequencer.sv
// tb/tb_hue_sequencer.sv - self-checking bench for hue_sequencer
module tb_hue_sequencer;

    localparam int TICK_DIV = 4;
    localparam int PWM_MAX  = 8;
    localparam int DUTY_W   = 8;
    localparam int WHEEL    = 6 * PWM_MAX;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b1;
    logic              pps = 1'b1;
    logic [DUTY_W-1:0] red_duty;
    logic [DUTY_W-1:0] green_duty;
    logic [DUTY_W-1:0] blue_duty;
    logic [2:0]        sector;
    logic              update;

    int checks = 0;
    int errors = 0;

    hue_sequencer #(
        .TICK_DIV (TICK_DIV),
        .PWM_MAX  (PWM_MAX),
        .DUTY_W   (DUTY_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (en),
        .pwm_period_start (pps),
        .red_duty         (red_duty),
        .green_duty       (green_duty),
        .blue_duty        (blue_duty),
        .sector           (sector),
        .update           (update)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rgb(input string name, input int r, input int g, input int b);
        check({name, "_r"}, 32'(red_duty), r);
        check({name, "_g"}, 32'(green_duty), g);
        check({name, "_b"}, 32'(blue_duty), b);
    endtask

    // Colour at a given position on the wheel, from the sector table.
    function automatic void colour(input int steps, output int r, output int g, output int b);
        int s, up, dn;
        s  = steps / PWM_MAX;
        up = steps % PWM_MAX;
        dn = PWM_MAX - up;
        case (s)
            0: begin r = PWM_MAX; g = up;      b = 0;       end
            1: begin r = dn;      g = PWM_MAX; b = 0;       end
            2: begin r = 0;       g = PWM_MAX; b = up;      end
            3: begin r = 0;       g = dn;      b = PWM_MAX; end
            4: begin r = up;      g = 0;       b = PWM_MAX; end
            default: begin r = PWM_MAX; g = 0; b = dn;      end
        endcase
    endfunction

    // Model: position on the wheel as a plain step count, plus prescaler phase.
    int m_phase = 0;
    int m_steps = 0;
    int m_r = 0, m_g = 0, m_b = 0;
    int m_upd = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_steps = 0;
            m_r = 0; m_g = 0; m_b = 0; m_upd = 0;
        end else begin
            if (pps) begin
                colour(m_steps, m_r, m_g, m_b);
                m_upd = 1;
            end else begin
                m_upd = 0;
            end
            if (en) begin
                m_phase = m_phase + 1;
                if (m_phase == TICK_DIV) begin
                    m_phase = 0;
                    m_steps = (m_steps + 1) % WHEEL;
                end
            end
        end
    end

    bit started = 0;
    bit onestep = 0;
    int p_r = 0, p_g = 0, p_b = 0;

    always @(negedge clk) begin
        if (started) begin
            int d;
            check("red",    32'(red_duty),   m_r);
            check("green",  32'(green_duty), m_g);
            check("blue",   32'(blue_duty),  m_b);
            check("sector", 32'(sector),     m_steps / PWM_MAX);
            check("update", 32'(update),     m_upd);
            d = ((int'(red_duty)   > p_r) ? int'(red_duty)   - p_r : p_r - int'(red_duty))
              + ((int'(green_duty) > p_g) ? int'(green_duty) - p_g : p_g - int'(green_duty))
              + ((int'(blue_duty)  > p_b) ? int'(blue_duty)  - p_b : p_b - int'(blue_duty));
            if (onestep && d != 0) check("one_channel_step", d, 1);
            p_r = int'(red_duty); p_g = int'(green_duty); p_b = int'(blue_duty);
        end
    end

    task automatic do_reset(input logic pps_val);
        rst = 1'b1; en = 1'b1; pps = pps_val; onestep = 0;
        repeat (2) @(negedge clk);
        started = 1;
        chk_rgb("in_reset", 0, 0, 0);
        check("in_reset_upd", 32'(update), 0);
        check("in_reset_sector", 32'(sector), 0);
        rst = 1'b0;
    endtask

    initial begin
        // Continuous commit walk over a full wheel.
        do_reset(1'b1);
        for (int e = 1; e <= 193; e++) begin
            @(negedge clk);
            case (e)
                1:   begin chk_rgb("first_commit", 8, 0, 0); check("first_upd", 32'(update), 1); end
                3:   onestep = 1;
                4:   chk_rgb("pre_step", 8, 0, 0);
                5:   chk_rgb("step1", 8, 1, 0);
                32:  begin check("sector1", 32'(sector), 1); chk_rgb("s0_l7", 8, 7, 0); end
                33:  chk_rgb("s1_l0", 8, 8, 0);
                65:  chk_rgb("s2_l0", 0, 8, 0);
                129: chk_rgb("s4_l0", 0, 0, 8);
                192: begin check("wrap_sector", 32'(sector), 0); chk_rgb("s5_l7", 8, 0, 1); end
                193: chk_rgb("wrap_red", 8, 0, 0);
                default: ;
            endcase
        end
        onestep = 0;

        // Sparse period starts: ticks between pulses coalesce.
        do_reset(1'b0);
        for (int e = 1; e <= 60; e++) begin
            pps = (e % 10 == 0);
            @(negedge clk);
            if (e == 9)  chk_rgb("no_commit_yet", 0, 0, 0);
            if (e == 10) chk_rgb("coalesce10", 8, 2, 0);
            if (e == 11) check("upd_low_after", 32'(update), 0);
            if (e == 20) chk_rgb("coalesce20", 8, 4, 0);
        end

        // Tick and period start on the same edge.
        do_reset(1'b0);
        for (int e = 1; e <= 6; e++) begin
            pps = (e == 4 || e == 6);
            @(negedge clk);
            if (e == 4) begin chk_rgb("coinc_old", 8, 0, 0); check("coinc_upd", 32'(update), 1); end
            if (e == 5) check("coinc_upd_low", 32'(update), 0);
            if (e == 6) chk_rgb("coinc_new", 8, 1, 0);
        end

        // Freeze in sector 3 and resume from the stopped prescaler phase.
        do_reset(1'b1);
        repeat (110) @(negedge clk);
        check("frz_sector", 32'(sector), 3);
        chk_rgb("frz_before", 0, 5, 8);
        en = 1'b0;
        repeat (50) @(negedge clk);
        chk_rgb("frz_held", 0, 5, 8);
        check("frz_upd", 32'(update), 1);
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk_rgb("resume_tick_edge", 0, 5, 8);
        @(negedge clk);
        chk_rgb("resume_step", 0, 4, 8);

        // Reset pulse in sector 4 level 5.
        do_reset(1'b1);
        repeat (149) @(negedge clk);
        check("s4_sector", 32'(sector), 4);
        chk_rgb("s4_l5", 5, 0, 8);
        rst = 1'b1;
        @(negedge clk);
        chk_rgb("mid_reset", 0, 0, 0);
        check("mid_reset_sector", 32'(sector), 0);
        check("mid_reset_upd", 32'(update), 0);
        rst = 1'b0;
        @(negedge clk);
        chk_rgb("after_reset", 8, 0, 0);
        check("after_reset_upd", 32'(update), 1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
